// File: rtl/regfile_param.sv
// regfile_param: 2-read/1-write register file with post-reset clear engine, optional bypass and syscall taps
module regfile_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1,
    parameter bit BYPASS     = 1,
    parameter int TAP0_IDX   = 2,
    parameter int TAP1_IDX   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] read_reg_1,
    input  logic [ADDR_WIDTH-1:0] read_reg_2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2,
    output logic [DATA_WIDTH-1:0] tap_0,
    output logic [DATA_WIDTH-1:0] tap_1,
    output logic                  ready
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] T0 = ADDR_WIDTH'(TAP0_IDX);
    localparam logic [ADDR_WIDTH-1:0] T1 = ADDR_WIDTH'(TAP1_IDX);
    localparam logic [ADDR_WIDTH-1:0] Z = '0;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clear_idx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  we;
    logic                  byp_1;
    logic                  byp_2;

    // we already excludes dropped zero-register writes, so bypass inherits that gating
    assign we    = (state == RUN) && reg_write && !(ZERO_REG && write_reg == Z);
    assign byp_1 = BYPASS && we && write_reg == read_reg_1;
    assign byp_2 = BYPASS && we && write_reg == read_reg_2;

    assign read_data_1 = !ready ? '0 : (ZERO_REG && read_reg_1 == Z) ? '0 :
                         byp_1 ? write_data : mem[read_reg_1];
    assign read_data_2 = !ready ? '0 : (ZERO_REG && read_reg_2 == Z) ? '0 :
                         byp_2 ? write_data : mem[read_reg_2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR)
                mem[clear_idx] <= '0;
            else if (we)
                mem[write_reg] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clear_idx <= '0;
            ready     <= 1'b0;
            tap_0     <= '0;
            tap_1     <= '0;
        end else if (state == CLEAR) begin
            clear_idx <= clear_idx + 1'b1;
            tap_0     <= '0;
            tap_1     <= '0;
            if (clear_idx == LAST) begin
                state <= RUN;
                ready <= 1'b1;
            end
        end else begin
            tap_0 <= (ZERO_REG && T0 == Z) ? '0 : (we && write_reg == T0) ? write_data : mem[T0];
            tap_1 <= (ZERO_REG && T1 == Z) ? '0 : (we && write_reg == T1) ? write_data : mem[T1];
        end
    end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed checks of clear engine, bypass gating, zero register and taps
module tb_regfile_param;
    logic        clk = 0;
    logic        rst = 1;
    logic [4:0]  read_reg_1 = 0, read_reg_2 = 0, write_reg = 0;
    logic [31:0] write_data = 0;
    logic        reg_write = 0;
    logic [31:0] rd1, rd2, t0, t1, nb_rd1, nb_rd2, nb_t0, nb_t1;
    logic        rdy, nb_rdy;
    int          passed = 0;
    int          total = 0;
    int          waited;

    always #5 clk = ~clk;

    regfile_param dut (
        .clk(clk), .rst(rst), .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
        .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .read_data_1(rd1), .read_data_2(rd2), .tap_0(t0), .tap_1(t1), .ready(rdy)
    );

    regfile_param #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
        .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .read_data_1(nb_rd1), .read_data_2(nb_rd2), .tap_0(nb_t0), .tap_1(nb_t1), .ready(nb_rdy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [4:0] idx, input logic [31:0] d);
        reg_write  = 1;
        write_reg  = idx;
        write_data = d;
        tick();
        reg_write  = 0;
    endtask

    task automatic clear_sequence(input string tag);
        for (int i = 1; i <= 32; i++) begin
            tick();
            check($sformatf("%s_ready_c%0d", tag, i), {31'b0, rdy}, (i == 32) ? 32'd1 : 32'd0);
        end
        check({tag, "_nb_ready"}, {31'b0, nb_rdy}, 32'd1);
    endtask

    initial begin
        tick();
        rst = 0;
        check("reset_ready", {31'b0, rdy}, 32'd0);
        check("reset_tap0", t0, 32'd0);
        check("reset_tap1", t1, 32'd0);
        check("reset_rd1", rd1, 32'd0);
        clear_sequence("clr1");
        for (int i = 0; i < 32; i++) begin
            read_reg_1 = 5'(i);
            read_reg_2 = 5'(31 - i);
            #1;
            check($sformatf("idle_r%0d", i), rd1 | rd2, 32'd0);
        end
        check("idle_tap0", t0, 32'd0);
        check("idle_tap1", t1, 32'd0);

        for (int i = 1; i < 32; i++) write(5'(i), 32'h0101_0101 * i);
        read_reg_1 = 9;
        #1;
        check("fill_r9", rd1, 32'h0909_0909);
        rst = 1;
        tick();
        rst = 0;
        repeat (10) tick();
        check("midclear_ready", {31'b0, rdy}, 32'd0);
        rst = 1;
        tick();
        rst = 0;
        clear_sequence("clr2");
        for (int i = 0; i < 32; i++) begin
            read_reg_1 = 5'(i);
            read_reg_2 = 5'(i);
            #1;
            check($sformatf("midclear_r%0d", i), rd1 | rd2 | nb_rd1, 32'd0);
        end

        read_reg_1 = 5;
        read_reg_2 = 5;
        reg_write  = 1;
        write_reg  = 5;
        write_data = 32'hDEADBEEF;
        #1;
        check("byp_rd1", rd1, 32'hDEADBEEF);
        check("byp_rd2", rd2, 32'hDEADBEEF);
        check("nobyp_rd1", nb_rd1, 32'd0);
        check("nobyp_rd2", nb_rd2, 32'd0);
        tick();
        reg_write = 0;
        #1;
        check("after_rd1", rd1, 32'hDEADBEEF);
        check("after_nb_rd2", nb_rd2, 32'hDEADBEEF);

        read_reg_1 = 0;
        read_reg_2 = 5;
        reg_write  = 1;
        write_reg  = 0;
        write_data = 32'h12345678;
        #1;
        check("zero_same", rd1, 32'd0);
        check("zero_other", rd2, 32'hDEADBEEF);
        tick();
        reg_write = 0;
        #1;
        check("zero_next", rd1, 32'd0);
        check("zero_next_nb", nb_rd1, 32'd0);

        write(7, 32'h11);
        read_reg_1 = 7;
        write_reg  = 7;
        write_data = 32'hFFFFFFFF;
        reg_write  = 0;
        #1;
        check("nofwd_rd1", rd1, 32'h11);
        check("nofwd_nb", nb_rd1, 32'h11);

        write(2, 32'd10);
        check("tap0_w", t0, 32'd10);
        check("tap1_pre", t1, 32'd0);
        write(4, 32'h1000);
        check("tap1_w", t1, 32'h1000);
        check("tap0_hold", t0, 32'd10);
        check("nb_tap0", nb_t0, 32'd10);

        rst = 1;
        tick();
        rst = 0;
        check("rst_tap0", t0, 32'd0);
        read_reg_1 = 2;
        reg_write  = 1;
        write_reg  = 2;
        write_data = 32'hAB;
        #1;
        check("clear_rd_gate", rd1, 32'd0);
        repeat (20) tick();
        check("clear_tap0", t0, 32'd0);
        check("clear_rd_gate2", rd1, 32'd0);
        reg_write = 0;
        waited = 0;
        while (!rdy && waited < 40) begin
            tick();
            waited++;
        end
        check("clear_ready_bound", {31'b0, rdy}, 32'd1);
        check("guard_r2", rd1, 32'd0);
        tick();
        check("guard_tap0", t0, 32'd0);
        check("guard_tap1", t1, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
